// File: rtl/lower_inverse_gram_stage_pkg.sv
// Shared constants, state encoding and reduction helpers for the Gram stage (A_inv = L_inv^H * L_inv).
// Build option GRAM_SATURATE_EN: saturating DW reduction and mirror negation instead of two's-complement wrap.
package chol_inv_pkg;
  localparam int N    = 8;
  localparam int DW   = 32;
  localparam int FRAC = 29;
  localparam int AW   = 2 * DW;
  localparam int CW   = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  // Each (i,j) pair costs N-j MAC cycles plus one WRITE, and column j holds j+1 pairs.
  function automatic int gram_latency(input int n);
    int s;
    s = 0;
    for (int j = 0; j < n; j++) s += (j + 1) * (n + 1 - j);
    return s;
  endfunction

  localparam int GRAM_LAT = gram_latency(N);

  function automatic int idx(input int r, input int c);
    return r * N + c;
  endfunction

`ifdef GRAM_SATURATE_EN
  localparam logic signed [AW-1:0] ACC_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  function automatic logic [DW-1:0] reduce_dw(input logic signed [AW-1:0] v);
`ifdef GRAM_SATURATE_EN
    if (v > ACC_MAX) return {1'b0, {(DW-1){1'b1}}};
    if (v < ACC_MIN) return {1'b1, {(DW-1){1'b0}}};
`endif
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] negate_dw(input logic [DW-1:0] x);
`ifdef GRAM_SATURATE_EN
    if (x == {1'b1, {(DW-1){1'b0}}}) return {1'b0, {(DW-1){1'b1}}};
`endif
    return -x;
  endfunction
endpackage

// File: rtl/lower_inverse_gram_stage_if.sv
// Start/complete handshake plus flat matrix buses between the lower-inverse and Gram stages.
interface lower_inverse_gram_stage_if;
  localparam int MW = chol_inv_pkg::N * chol_inv_pkg::N * chol_inv_pkg::DW;

  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] L_inv_real_in;
  logic [MW-1:0] L_inv_imag_in;
  logic [MW-1:0] A_inv_real_out;
  logic [MW-1:0] A_inv_imag_out;
  logic          out_valid;

  modport master (
    output in_valid, L_inv_real_in, L_inv_imag_in,
    input  in_ready, A_inv_real_out, A_inv_imag_out, out_valid
  );

  modport slave (
    input  in_valid, L_inv_real_in, L_inv_imag_in,
    output in_ready, A_inv_real_out, A_inv_imag_out, out_valid
  );
endinterface

// File: rtl/lower_inverse_gram_stage_mac.sv
// One conj(a)*b accumulate step per enabled cycle; each term is rescaled by FRAC before accumulation.
module complex_conj_mac
  import chol_inv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] ar,
  input  logic signed [DW-1:0] ai,
  input  logic signed [DW-1:0] br,
  input  logic signed [DW-1:0] bi,
  output logic signed [AW-1:0] acc_re,
  output logic signed [AW-1:0] acc_im
);
  logic signed [AW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [AW-1:0] t_re, t_im;
  logic signed [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;

  assign ar_x = {{DW{ar[DW-1]}}, ar};
  assign ai_x = {{DW{ai[DW-1]}}, ai};
  assign br_x = {{DW{br[DW-1]}}, br};
  assign bi_x = {{DW{bi[DW-1]}}, bi};

  assign t_re = (ar_x * br_x + ai_x * bi_x) >>> FRAC;
  assign t_im = (ar_x * bi_x - ai_x * br_x) >>> FRAC;

  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    if (clr) begin
      acc_re_d = '0;
      acc_im_d = '0;
    end else if (en) begin
      acc_re_d = acc_re_q + t_re;
      acc_im_d = acc_im_q + t_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
    end
  end

  assign acc_re = acc_re_q;
  assign acc_im = acc_im_q;
endmodule

// File: rtl/lower_inverse_gram_stage.sv
// Gram stage: A_inv = L_inv^H * L_inv, upper triangle by sequential conj-MAC, lower triangle mirrored.
// Reduction behaviour selected by GRAM_SATURATE_EN (see chol_inv_pkg).
module lower_inverse_gram_stage
  import chol_inv_pkg::*;
(
  input logic                     clk,
  input logic                     rst_n,
  lower_inverse_gram_stage_if.slave bus
);
  localparam int            MW   = N * N * DW;
  localparam int            PW   = $clog2(MW);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [MW-1:0]        l_re_q, l_re_d, l_im_q, l_im_d;
  logic [MW-1:0]        a_re_q, a_re_d, a_im_q, a_im_d;
  logic                 out_valid_q, out_valid_d;
  logic                 mac_clr, mac_en;
  logic [PW-1:0]        off_ki, off_kj, off_ij, off_ji;
  logic signed [DW-1:0] ar, ai, br, bi;
  logic signed [AW-1:0] acc_re, acc_im;
  logic [DW-1:0]        re_w, im_w, im_mirror;
  logic                 diag;

  // Operand a = L_inv[k][i], b = L_inv[k][j]; k >= j >= i keeps reads in the lower triangle.
  assign off_ki = PW'(idx(int'(k_q), int'(i_q)) * DW);
  assign off_kj = PW'(idx(int'(k_q), int'(j_q)) * DW);
  assign off_ij = PW'(idx(int'(i_q), int'(j_q)) * DW);
  assign off_ji = PW'(idx(int'(j_q), int'(i_q)) * DW);

  assign ar = l_re_q[off_ki +: DW];
  assign ai = l_im_q[off_ki +: DW];
  assign br = l_re_q[off_kj +: DW];
  assign bi = l_im_q[off_kj +: DW];

  complex_conj_mac u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .ar     (ar),
    .ai     (ai),
    .br     (br),
    .bi     (bi),
    .acc_re (acc_re),
    .acc_im (acc_im)
  );

  assign diag      = (i_q == j_q);
  assign re_w      = reduce_dw(acc_re);
  assign im_w      = diag ? '0 : reduce_dw(acc_im);
  assign im_mirror = diag ? '0 : negate_dw(im_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = MAC;
      MAC:     if (k_q == LAST) state_d = WRITE;
      WRITE:   state_d = (i_q == LAST && j_q == LAST) ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    l_re_d      = l_re_q;
    l_im_d      = l_im_q;
    a_re_d      = a_re_q;
    a_im_d      = a_im_q;
    out_valid_d = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          l_re_d  = bus.L_inv_real_in;
          l_im_d  = bus.L_inv_imag_in;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q != LAST) k_d = k_q + CW'(1);
      end
      WRITE: begin
        a_re_d[off_ij +: DW] = re_w;
        a_im_d[off_ij +: DW] = im_w;
        a_re_d[off_ji +: DW] = re_w;
        a_im_d[off_ji +: DW] = im_mirror;
        mac_clr = 1'b1;
        if (j_q != LAST) begin
          j_d = j_q + CW'(1);
          k_d = j_q + CW'(1);
        end else if (i_q != LAST) begin
          i_d = i_q + CW'(1);
          j_d = i_q + CW'(1);
          k_d = i_q + CW'(1);
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      l_re_q      <= '0;
      l_im_q      <= '0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      l_re_q      <= l_re_d;
      l_im_q      <= l_im_d;
      a_re_q      <= a_re_d;
      a_im_q      <= a_im_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.out_valid      = out_valid_q;
  assign bus.A_inv_real_out = a_re_q;
  assign bus.A_inv_imag_out = a_im_q;
endmodule

// File: tb/tb_lower_inverse_gram_stage.sv
// Bench for lower_inverse_gram_stage: directed table, random matrices vs. a matrix-level model, abort/ignore cases.
module tb_lower_inverse_gram_stage;
  localparam int N       = 8;
  localparam int DW      = 32;
  localparam int FRAC    = 29;
  localparam int MW      = N * N * DW;
  localparam int EXP_LAT = 156;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lr[N][N], li[N][N], xr[N][N], xi[N][N];

  typedef struct {
    int d_re; int d_im; int l10;
    int e_diag; int e_a00; int e_a01;
  } vec_t;
  vec_t tbl[5];

  lower_inverse_gram_stage_if bus_if ();

  lower_inverse_gram_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic int red(input longint v);
`ifdef GRAM_SATURATE_EN
    if (v > 64'sd2147483647)  return 32'h7fffffff;
    if (v < -64'sd2147483648) return 32'h80000000;
`endif
    return int'(v);
  endfunction

  function automatic int neg(input int x);
`ifdef GRAM_SATURATE_EN
    if (x == 32'h80000000) return 32'h7fffffff;
`endif
    return -x;
  endfunction

  // Hermitian product: A[i][j] = sum_k conj(L[k][i]) * L[k][j], lower-triangular L.
  task automatic model();
    for (int i = 0; i < N; i++)
      for (int j = i; j < N; j++) begin
        longint sr, si;
        sr = 0;
        si = 0;
        for (int k = j; k < N; k++) begin
          longint ar, ai, br, bi;
          ar = lr[k][i]; ai = li[k][i]; br = lr[k][j]; bi = li[k][j];
          sr += (ar * br + ai * bi) >>> FRAC;
          si += (ar * bi - ai * br) >>> FRAC;
        end
        xr[i][j] = red(sr);
        xr[j][i] = red(sr);
        xi[i][j] = (i == j) ? 0 : red(si);
        xi[j][i] = (i == j) ? 0 : neg(red(si));
      end
  endtask

  function automatic logic [MW-1:0] pack(input int m[N][N]);
    logic [MW-1:0] p;
    p = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        p = p | ({{(MW-32){1'b0}}, m[r][c]} << ((r * N + c) * DW));
    return p;
  endfunction

  function automatic logic [MW-1:0] junk();
    logic [MW-1:0] p;
    p = '0;
    repeat (N * N) p = (p << 32) | MW'($urandom);
    return p;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic chk_mat(input string name);
    int bad;
    logic [MW-1:0] sre, sim;
    int gr, gi;
    bad = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sre = bus_if.A_inv_real_out >> ((r * N + c) * DW);
        sim = bus_if.A_inv_imag_out >> ((r * N + c) * DW);
        gr  = int'(sre[31:0]);
        gi  = int'(sim[31:0]);
        if (gr != xr[r][c] || gi != xi[r][c]) begin
          if (bad == 0)
            $display("FAIL %s A[%0d][%0d]: got re=%h im=%h expected re=%h im=%h",
                     name, r, c, gr, gi, xr[r][c], xi[r][c]);
          bad++;
        end
      end
    checks++;
    if (bad != 0) errors++;
  endtask

  // Called at a negedge; drives the start immediately so back-to-back starts hit the first IDLE cycle.
  task automatic run_op(input int pulse_at, output int lat);
    bus_if.L_inv_real_in = pack(lr);
    bus_if.L_inv_imag_in = pack(li);
    bus_if.in_valid      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid      = 1'b0;
    bus_if.L_inv_real_in = junk();
    bus_if.L_inv_imag_in = junk();
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus_if.in_valid = (lat == pulse_at) && !bus_if.out_valid;
    end while (!bus_if.out_valid && lat < 2000);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic do_op(input string name, input int pulse_at, input bit use_model);
    int lat;
    if (use_model) model();
    run_op(pulse_at, lat);
    chk({name, " latency"}, lat, EXP_LAT);
    @(negedge clk);
    chk({name, " out_valid width"}, bus_if.out_valid, 0);
    chk({name, " in_ready after done"}, bus_if.in_ready, 1);
    chk_mat(name);
  endtask

  task automatic rand_L(input int sh);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        lr[r][c] = $signed($urandom) >>> sh;
        li[r][c] = $signed($urandom) >>> sh;
      end
  endtask

  initial begin
    int sat_exp, seen;
`ifdef GRAM_SATURATE_EN
    sat_exp = 32'h7fffffff;
`else
    sat_exp = 32'h80000000;
`endif
    tbl[0] = '{32'h20000000, 0,            0,            32'h20000000, 32'h20000000, 0};
    tbl[1] = '{32'h10000000, 0,            0,            32'h08000000, 32'h08000000, 0};
    tbl[2] = '{0,            32'h20000000, 0,            32'h20000000, 32'h20000000, 0};
    tbl[3] = '{32'h20000000, 0,            32'h10000000, 32'h20000000, 32'h28000000, 32'h10000000};
    tbl[4] = '{32'h40000000, 0,            0,            sat_exp,      sat_exp,      0};

    bus_if.in_valid      = 1'b0;
    bus_if.L_inv_real_in = '0;
    bus_if.L_inv_imag_in = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", bus_if.in_ready, 1);
    chk("reset out_valid", bus_if.out_valid, 0);
    chk("reset real bus", |bus_if.A_inv_real_out, 0);
    chk("reset imag bus", |bus_if.A_inv_imag_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[t]) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          lr[r][c] = (r == c) ? tbl[t].d_re : 0;
          li[r][c] = (r == c) ? tbl[t].d_im : 0;
          xr[r][c] = (r == c) ? ((r == 0) ? tbl[t].e_a00 : tbl[t].e_diag)
                              : ((r + c == 1) ? tbl[t].e_a01 : 0);
          xi[r][c] = 0;
        end
      lr[1][0] = tbl[t].l10;
      do_op($sformatf("vec%0d", t), -1, 1'b0);
    end

    rand_L(2); do_op("rand_ignored_start", 50, 1'b1);
    rand_L(2); do_op("rand_a", -1, 1'b1);
    rand_L(3); do_op("rand_b", -1, 1'b1);
    rand_L(0); do_op("rand_full_range", -1, 1'b1);

    rand_L(2);
    bus_if.L_inv_real_in = pack(lr);
    bus_if.L_inv_imag_in = pack(li);
    bus_if.in_valid      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("busy in_ready", bus_if.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", bus_if.in_ready, 1);
    chk("abort out_valid", bus_if.out_valid, 0);
    chk("abort real bus", |bus_if.A_inv_real_out, 0);
    chk("abort imag bus", |bus_if.A_inv_imag_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus_if.out_valid) seen++;
    end
    chk("no out_valid after abort", seen, 0);

    rand_L(2); do_op("post_abort", -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lower_inverse_gram_stage.md
Name: lower_inverse_gram_stage

Overview:
- Final stage of the Cholesky-based matrix inverse. Consumes the lower-triangular inverse L_inv produced by the lower-inverse stage.
- Computes A_inv = L_inv^H * L_inv for an N x N complex Hermitian result.
- Sequential conjugate-MAC engine; computes the upper triangle only and mirrors the lower triangle by conjugation.
- Same flat-bus format and Q2.29 fixed point as the upstream stage.

Parameters:
- N, 8, matrix dimension.
- DW, 32, element width (signed, per real/imag part).
- FRAC, 29, fractional bits (Q2.29).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  single-cycle start pulse; sampled only when in_ready=1
- in_ready  out  1  high in IDLE
- L_inv_real_in  in  N*N*DW  real parts; element r*N+c at bits [(idx+1)*DW-1 -: DW]
- L_inv_imag_in  in  N*N*DW  imag parts, same packing
- A_inv_real_out  out  N*N*DW  result real parts, same packing
- A_inv_imag_out  out  N*N*DW  result imag parts
- out_valid  out  1  one-cycle completion pulse

Behaviour:
- Reset (async): state=IDLE; out_valid=0; in_ready=1; all result and capture registers=0, so both output buses read 0; counters and accumulators=0.
- States:
  - IDLE: on in_valid, capture both input buses into internal registers, set i=0, j=0, k=0, clear accumulators, go to MAC.
  - MAC: accumulate one term per cycle. When k==N-1, go to WRITE; otherwise increment k.
  - WRITE: store the element and its mirror. Then:
    - if j<N-1: j++;
    - else if i<N-1: i++, j=i+1 (i.e. j=new i);
    - else go to DONE with out_valid<=1.
    - On every advance, k reloads to the new j and the accumulators clear.
  - DONE: out_valid<=0, go to IDLE.
- Term for (i,j,k), where a=L_inv[k][i] and b=L_inv[k][j]:
  - re += (ar*br + ai*bi) >>> FRAC
  - im += (ar*bi - ai*br) >>> FRAC
  - Products are full 2*DW signed; accumulators are 2*DW signed.
  - k runs from j to N-1; upper-triangle entries of L_inv are never read.
- Write, with the accumulator reduced to DW bits: A[i][j] = (re, im); A[j][i] = (re, -im). On the diagonal (i==j), imag is forced to 0.
- Output buses are a continuous mapping of the result registers.
  - Valid from the out_valid cycle until the next accepted in_valid.
  - Intermediate values are visible during compute; consumers must qualify with out_valid.
- Latency: the edge sampling in_valid is edge t; out_valid is registered high on edge t+L, with L = sum over j=0..N-1 of (j+1)(N+1-j). L=156 for N=8.
- in_valid while not IDLE is ignored, with no queuing.
- Back-to-back: in_valid is accepted in the cycle after DONE (the first IDLE cycle).
- Reset mid-operation aborts immediately to the reset state; no out_valid.
- Counters are sized $clog2(N)+1 bits so the terminal compare cannot wrap.
- Input buses need only be stable in the accept cycle.

Optional Feature:
- Macro: GRAM_SATURATE_EN.
- Defined: reduction to DW bits saturates to [-2^(DW-1), 2^(DW-1)-1]. Negating -2^(DW-1) for a mirror imag saturates to 2^(DW-1)-1.
- Undefined: reduction keeps the low DW bits (two's-complement wrap), and negation wraps.

Decomposition:
- Package chol_inv_pkg holds:
  - N, DW, FRAC;
  - the state enum (IDLE, MAC, WRITE, DONE);
  - the latency constant;
  - an index function idx(r,c)=r*N+c.
- Sub-module complex_conj_mac: one registered conj(a)*b accumulate step with clear and enable inputs, 2*DW accumulator. Instantiated once.

Test Plan:
- Identity input (diag real 0x20000000, rest 0) -> A_inv = identity; out_valid exactly 156 cycles after the accept edge, high for 1 cycle.
- Diag real 0x10000000 (0.5) -> diag real 0x08000000, all imag 0, off-diagonals 0.
- Diag imag 0x20000000 (j*1.0), real 0 -> diag real 0x20000000, diag imag 0.
- Identity plus L_inv[1][0]=0x10000000 -> A[0][0]=0x28000000; A[0][1]=A[1][0]=0x10000000; all else identity.
- Diag real 0x40000000 (2.0) -> diag is 0x7FFFFFFF with GRAM_SATURATE_EN, 0x80000000 without.
- Pulse in_valid at cycle 50 of a run -> ignored, single out_valid at 156. Then assert rst_n=0 mid-run -> outputs 0, no out_valid, in_ready=1.
